// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between the fetcher and memory port 0.
// Define ICACHE_STATS_EN to build the hit/miss counters; otherwise both counter ports read as zero.
module icache #(
  parameter int LINES      = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  input  logic                  flush,
  output logic                  resp_valid,
  output logic [31:0]           resp_inst,
  output logic [1:0]            mem_rw_flag,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [1:0]            mem_len,
  input  logic                  mem_busy,
  input  logic                  mem_done,
  input  logic [31:0]           mem_data,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);

  localparam int IDX = $clog2(LINES);
  localparam int TAG = ADDR_WIDTH - IDX - 2;

  typedef enum logic [1:0] {IDLE, MISS, FILL} state_t;

  state_t                  state;
  logic [LINES-1:0]        valid_q;
  logic [TAG-1:0]          tag_q  [LINES];
  logic [31:0]             data_q [LINES];
  logic [ADDR_WIDTH-1:2]   addr_q;
  logic                    resp_q;
  logic                    miss_flushed;

  logic [IDX-1:0]          req_idx;
  logic [TAG-1:0]          req_tag;
  logic [IDX-1:0]          line_idx;
  logic [TAG-1:0]          line_tag;
  logic                    lookup_hit;
  logic                    accept;
  logic                    fill_done;
  logic                    unused_sigs;

  assign req_idx    = req_addr[IDX+1:2];
  assign req_tag    = req_addr[ADDR_WIDTH-1:IDX+2];
  assign line_idx   = addr_q[IDX+1:2];
  assign line_tag   = addr_q[ADDR_WIDTH-1:IDX+2];
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign req_ready  = (state == IDLE) && rdy;
  assign accept     = req_valid && req_ready && !flush;
  assign fill_done  = (state == MISS) && rdy && mem_done;

  // A redirect hides whatever response is on the wire this cycle.
  assign resp_valid  = resp_q && !flush;
  assign unused_sigs = &{1'b0, mem_busy, req_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      valid_q      <= '0;
      addr_q       <= '0;
      resp_q       <= 1'b0;
      resp_inst    <= '0;
      mem_rw_flag  <= 2'b00;
      mem_addr     <= '0;
      mem_len      <= 2'b00;
      miss_flushed <= 1'b0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          resp_q <= 1'b0;
          if (accept) begin
            addr_q <= req_addr[ADDR_WIDTH-1:2];
            if (lookup_hit) begin
              resp_q    <= 1'b1;
              resp_inst <= data_q[req_idx];
            end else begin
              state        <= MISS;
              mem_rw_flag  <= 2'b01;
              mem_addr     <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_len      <= 2'b11;
              miss_flushed <= 1'b0;
            end
          end
        end
        MISS: begin
          // The read cannot be cancelled, so a flush only marks the answer as unwanted.
          if (flush) miss_flushed <= 1'b1;
          if (mem_done) begin
            valid_q[line_idx] <= 1'b1;
            state             <= FILL;
            mem_rw_flag       <= 2'b00;
            mem_len           <= 2'b00;
            if (!(flush || miss_flushed)) begin
              resp_q    <= 1'b1;
              resp_inst <= mem_data;
            end
          end
        end
        FILL: begin
          resp_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[line_idx]  <= line_tag;
      data_q[line_idx] <= mem_data;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (lookup_hit) hit_cnt  <= hit_cnt + 32'd1;
      else            miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule
